// File: rtl/snn_seq_pkg.sv
// Shared state encoding and run-mode constants for the SNN run sequencer.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_STEP   = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } seq_state_e;

  localparam logic MODE_CONFIG = 1'b0;
  localparam logic MODE_INFER  = 1'b1;

endpackage

// File: rtl/snn_run_sequencer_key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser plus stability counter that
// only moves the clean level after DEBOUNCE_CYC consecutive differing cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_clean
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Key idles high, so the synchroniser and clean level reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clean_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_clean = clean_q;

endmodule

// File: rtl/snn_run_sequencer.sv
// SNN accelerator run controller: mode key, weight load, timestep sequencing.
// Optional per-timestep timeout enabled by defining SNN_STEP_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for mode toggle, power-up load or frame start
// S_CONFIG | streaming weight words into core memory
// S_STEP   | one-cycle timestep start pulse
// S_WAIT   | waiting for timestep done from the core
// S_RESULT | one-cycle result valid pulse
module snn_run_sequencer
  import snn_seq_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int N_WEIGHT_WORDS = 1024,
  parameter int N_TIMESTEPS    = 16,
  parameter int CLASS_W        = 4,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int TIMEOUT_CYC    = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Key_Signal,
  input  logic               Start_Infer,
  input  logic               Wt_Valid,
  input  logic [WORD_W-1:0]  Wt_Data,
  output logic               Wt_Ready,
  output logic               Core_Wr_En,
  output logic [ADDR_W-1:0]  Core_Wr_Addr,
  output logic [WORD_W-1:0]  Core_Wr_Data,
  output logic               Core_Step_Start,
  input  logic               Core_Step_Done,
  input  logic [CLASS_W-1:0] Core_Result,
  output logic               Result_Valid,
  output logic [CLASS_W-1:0] Result_Class,
  output logic               Run_Mode,
  output logic               Weights_Loaded,
  output logic               Busy,
  output logic               LED_Show_Config,
  output logic               LED_Show_Car,
  output logic               Timeout_Err
);

  localparam int STEP_W = (N_TIMESTEPS > 1) ? $clog2(N_TIMESTEPS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHT_WORDS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_TIMESTEPS - 1);

  seq_state_e         state_q, state_d;
  logic               run_mode_q, run_mode_d;
  logic               loaded_q, loaded_d;
  logic               pend_q, pend_d;
  logic               key_prev_q, key_prev_d;
  logic               led_cfg_q, led_cfg_d;
  logic               led_car_q, led_car_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               key_clean;
  logic               key_evt;
  logic               toggle_req;
  logic               wt_ready;
  logic               wr_en;

`ifdef SNN_STEP_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk       (CLK),
    .rst       (RST),
    .key_raw   (Key_Signal),
    .key_clean (key_clean)
  );

  // Release of the button (clean level rising) is the user event.
  assign key_evt    = key_clean & ~key_prev_q;
  assign toggle_req = pend_q | key_evt;

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    loaded_d   = loaded_q;
    pend_d     = toggle_req;
    key_prev_d = key_clean;
    addr_d     = addr_q;
    step_d     = step_q;
    result_d   = result_q;
    wt_ready   = 1'b0;
    wr_en      = 1'b0;
`ifdef SNN_STEP_TIMEOUT_EN
    wait_d     = wait_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (toggle_req) begin
          pend_d     = 1'b0;
          run_mode_d = ~run_mode_q;
          if (run_mode_q == MODE_INFER) begin
            state_d  = S_CONFIG;
            loaded_d = 1'b0;
            addr_d   = '0;
          end
        end else if (run_mode_q == MODE_CONFIG && !loaded_q) begin
          state_d = S_CONFIG;
          addr_d  = '0;
        end else if (run_mode_q == MODE_INFER && Start_Infer && loaded_q) begin
          state_d = S_STEP;
          step_d  = '0;
        end
      end
      S_CONFIG: begin
        wt_ready = 1'b1;
        if (Wt_Valid) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
        // A key event abandons the load; any same-cycle word is still written.
        if (toggle_req) begin
          pend_d     = 1'b0;
          run_mode_d = ~run_mode_q;
          loaded_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_STEP: begin
        state_d = S_WAIT;
`ifdef SNN_STEP_TIMEOUT_EN
        wait_d  = WAIT_W'(TIMEOUT_CYC - 1);
`endif
      end
      S_WAIT: begin
        if (Core_Step_Done) begin
          if (step_q == LAST_STEP) begin
            result_d = Core_Result;
            state_d  = S_RESULT;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = S_STEP;
          end
        end
`ifdef SNN_STEP_TIMEOUT_EN
        else if (wait_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
`endif
      end
      S_RESULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    led_cfg_d = ~run_mode_d;
    led_car_d = run_mode_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      run_mode_q <= MODE_CONFIG;
      loaded_q   <= 1'b0;
      pend_q     <= 1'b0;
      key_prev_q <= 1'b1;
      led_cfg_q  <= 1'b1;
      led_car_q  <= 1'b0;
      addr_q     <= '0;
      step_q     <= '0;
      result_q   <= '0;
`ifdef SNN_STEP_TIMEOUT_EN
      wait_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      loaded_q   <= loaded_d;
      pend_q     <= pend_d;
      key_prev_q <= key_prev_d;
      led_cfg_q  <= led_cfg_d;
      led_car_q  <= led_car_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      result_q   <= result_d;
`ifdef SNN_STEP_TIMEOUT_EN
      wait_q     <= wait_d;
      err_q      <= err_d;
`endif
    end
  end

  assign Wt_Ready        = wt_ready;
  assign Core_Wr_En      = wr_en;
  assign Core_Wr_Addr    = addr_q;
  assign Core_Wr_Data    = Wt_Data;
  assign Core_Step_Start = (state_q == S_STEP);
  assign Result_Valid    = (state_q == S_RESULT);
  assign Result_Class    = result_q;
  assign Run_Mode        = run_mode_q;
  assign Weights_Loaded  = loaded_q;
  assign Busy            = (state_q != S_IDLE);
  assign LED_Show_Config = led_cfg_q;
  assign LED_Show_Car    = led_car_q;
`ifdef SNN_STEP_TIMEOUT_EN
  assign Timeout_Err     = err_q;
`else
  assign Timeout_Err     = 1'b0;
`endif

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Directed bench for snn_run_sequencer with small parameters (8 words, 4 steps).
module tb_snn_run_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Key_Signal;
  logic        Start_Infer;
  logic        Wt_Valid;
  logic [31:0] Wt_Data;
  logic        Wt_Ready;
  logic        Core_Wr_En;
  logic [2:0]  Core_Wr_Addr;
  logic [31:0] Core_Wr_Data;
  logic        Core_Step_Start;
  logic        Core_Step_Done;
  logic [3:0]  Core_Result;
  logic        Result_Valid;
  logic [3:0]  Result_Class;
  logic        Run_Mode;
  logic        Weights_Loaded;
  logic        Busy;
  logic        LED_Show_Config;
  logic        LED_Show_Car;
  logic        Timeout_Err;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_n    = 0;
  int start_n = 0;
  int rv_n    = 0;
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];

  snn_run_sequencer #(
    .WORD_W         (32),
    .ADDR_W         (3),
    .N_WEIGHT_WORDS (8),
    .N_TIMESTEPS    (4),
    .CLASS_W        (4),
    .DEBOUNCE_CYC   (4),
    .TIMEOUT_CYC    (10)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Key_Signal      (Key_Signal),
    .Start_Infer     (Start_Infer),
    .Wt_Valid        (Wt_Valid),
    .Wt_Data         (Wt_Data),
    .Wt_Ready        (Wt_Ready),
    .Core_Wr_En      (Core_Wr_En),
    .Core_Wr_Addr    (Core_Wr_Addr),
    .Core_Wr_Data    (Core_Wr_Data),
    .Core_Step_Start (Core_Step_Start),
    .Core_Step_Done  (Core_Step_Done),
    .Core_Result     (Core_Result),
    .Result_Valid    (Result_Valid),
    .Result_Class    (Result_Class),
    .Run_Mode        (Run_Mode),
    .Weights_Loaded  (Weights_Loaded),
    .Busy            (Busy),
    .LED_Show_Config (LED_Show_Config),
    .LED_Show_Car    (LED_Show_Car),
    .Timeout_Err     (Timeout_Err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    #3;
    if (Core_Wr_En && wr_n < 64) begin
      wr_addr_log[wr_n] = {29'd0, Core_Wr_Addr};
      wr_data_log[wr_n] = Core_Wr_Data;
      wr_n++;
    end
    if (Core_Step_Start) start_n++;
    if (Result_Valid) rv_n++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic key_toggle();
    Key_Signal = 1'b0;
    cyc(8);
    Key_Signal = 1'b1;
    cyc(10);
  endtask

  task automatic load_words(input int n, input logic [31:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      Wt_Valid = 1'b1;
      Wt_Data  = base + 32'(i);
      cyc();
      Wt_Valid = 1'b0;
      if (gaps && (i == 2 || i == 5)) cyc(2);
    end
  endtask

  task automatic check_writes(input int first, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("wr_addr[%0d]", first + i), wr_addr_log[first + i], 32'(i));
      chk($sformatf("wr_data[%0d]", first + i), wr_data_log[first + i], base + 32'(i));
    end
  endtask

  task automatic run_infer(input logic [3:0] res, input int d0, input bit rel_key);
    Start_Infer = 1'b1;
    cyc();
    Start_Infer = 1'b0;
    chk("start_latency", {31'd0, Core_Step_Start}, 1);
    if (rel_key) Key_Signal = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cyc((s == 0) ? d0 : 3);
      Core_Step_Done = 1'b1;
      Core_Result    = res;
      cyc();
      Core_Step_Done = 1'b0;
      if (s < 3) begin
        chk("done_to_start", {31'd0, Core_Step_Start}, 1);
      end else begin
        chk("result_valid", {31'd0, Result_Valid}, 1);
        chk("result_class", {28'd0, Result_Class}, {28'd0, res});
      end
    end
    cyc();
    chk("result_valid_len", {31'd0, Result_Valid}, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_run_mode"}, {31'd0, Run_Mode}, 0);
    chk({tag, "_led_cfg"}, {31'd0, LED_Show_Config}, 1);
    chk({tag, "_led_car"}, {31'd0, LED_Show_Car}, 0);
    chk({tag, "_loaded"}, {31'd0, Weights_Loaded}, 0);
    chk({tag, "_busy"}, {31'd0, Busy}, 0);
    chk({tag, "_step_start"}, {31'd0, Core_Step_Start}, 0);
    chk({tag, "_result_valid"}, {31'd0, Result_Valid}, 0);
    chk({tag, "_result_class"}, {28'd0, Result_Class}, 0);
    chk({tag, "_wt_ready"}, {31'd0, Wt_Ready}, 0);
    chk({tag, "_timeout_err"}, {31'd0, Timeout_Err}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int starts0;
    int rv0;
    RST            = 1'b1;
    Key_Signal     = 1'b1;
    Start_Infer    = 1'b0;
    Wt_Valid       = 1'b0;
    Wt_Data        = '0;
    Core_Step_Done = 1'b0;
    Core_Result    = '0;
    cyc(3);
    check_reset_vals("reset");

    // Power-up load with gaps in the stream
    RST = 1'b0;
    cyc();
    chk("pwrup_config_busy", {31'd0, Busy}, 1);
    chk("pwrup_wt_ready", {31'd0, Wt_Ready}, 1);
    load_words(8, 32'hA0, 1'b1);
    chk("load_loaded", {31'd0, Weights_Loaded}, 1);
    chk("load_idle", {31'd0, Busy}, 0);
    chk("load_wr_count", 32'(wr_n), 8);
    check_writes(0, 8, 32'hA0);

    // Clean press/release toggles to infer; falling edge alone does not
    Key_Signal = 1'b0;
    cyc(8);
    chk("press_no_toggle", {31'd0, Run_Mode}, 0);
    Key_Signal = 1'b1;
    cyc(10);
    chk("toggle_run_mode", {31'd0, Run_Mode}, 1);
    chk("toggle_led_car", {31'd0, LED_Show_Car}, 1);
    chk("toggle_led_cfg", {31'd0, LED_Show_Config}, 0);
    chk("toggle_idle", {31'd0, Busy}, 0);

    Key_Signal = 1'b0;
    cyc(2);
    Key_Signal = 1'b1;
    cyc(10);
    chk("glitch_no_toggle", {31'd0, Run_Mode}, 1);

    // Inference with Done three cycles after each Start
    starts0 = start_n;
    rv0     = rv_n;
    run_infer(4'd5, 3, 1'b0);
    chk("infer_start_count", 32'(start_n - starts0), 4);
    chk("infer_rv_count", 32'(rv_n - rv0), 1);
    chk("infer_idle", {31'd0, Busy}, 0);

    // Key released while waiting on the first timestep
    Key_Signal = 1'b0;
    cyc(8);
    starts0 = start_n;
    rv0     = rv_n;
    run_infer(4'd9, 10, 1'b1);
    chk("keyinf_start_count", 32'(start_n - starts0), 4);
    chk("keyinf_rv_count", 32'(rv_n - rv0), 1);
    chk("keyinf_mode_hold", {31'd0, Run_Mode}, 1);
    chk("keyinf_idle", {31'd0, Busy}, 0);
    cyc();
    chk("keyinf_mode_flip", {31'd0, Run_Mode}, 0);
    chk("keyinf_config", {31'd0, Busy}, 1);
    chk("keyinf_loaded_clr", {31'd0, Weights_Loaded}, 0);
    chk("keyinf_led_cfg", {31'd0, LED_Show_Config}, 1);
    chk("keyinf_wt_ready", {31'd0, Wt_Ready}, 1);

    // Abort a load after three words
    load_words(3, 32'hB0, 1'b0);
    key_toggle();
    chk("abort_idle", {31'd0, Busy}, 0);
    chk("abort_loaded", {31'd0, Weights_Loaded}, 0);
    chk("abort_run_mode", {31'd0, Run_Mode}, 1);
    chk("abort_wr_count", 32'(wr_n), 11);
    check_writes(8, 3, 32'hB0);

    // Start while unloaded is ignored
    starts0 = start_n;
    Start_Infer = 1'b1;
    cyc();
    Start_Infer = 1'b0;
    chk("ignore_no_start", {31'd0, Core_Step_Start}, 0);
    cyc(4);
    chk("ignore_start_count", 32'(start_n - starts0), 0);
    chk("ignore_idle", {31'd0, Busy}, 0);

    // Reload from address 0, then back to infer
    key_toggle();
    chk("reload_mode", {31'd0, Run_Mode}, 0);
    chk("reload_config", {31'd0, Busy}, 1);
    load_words(8, 32'hC0, 1'b0);
    chk("reload_loaded", {31'd0, Weights_Loaded}, 1);
    check_writes(11, 8, 32'hC0);
    key_toggle();
    chk("reload_infer", {31'd0, Run_Mode}, 1);

`ifdef SNN_STEP_TIMEOUT_EN
    rv0 = rv_n;
    Start_Infer = 1'b1;
    cyc();
    Start_Infer = 1'b0;
    chk("to_start", {31'd0, Core_Step_Start}, 1);
    cyc(10);
    chk("to_still_wait", {31'd0, Busy}, 1);
    chk("to_err_not_yet", {31'd0, Timeout_Err}, 0);
    cyc();
    chk("to_idle", {31'd0, Busy}, 0);
    chk("to_err", {31'd0, Timeout_Err}, 1);
    chk("to_no_result", 32'(rv_n - rv0), 0);
`endif

    // Reset in the middle of a timestep wait
    Start_Infer = 1'b1;
    cyc();
    Start_Infer = 1'b0;
    cyc(2);
    chk("rstmid_wait_busy", {31'd0, Busy}, 1);
    chk("rstmid_wait_nostart", {31'd0, Core_Step_Start}, 0);
    starts0 = start_n;
    RST = 1'b1;
    cyc();
    check_reset_vals("rstmid");
    RST = 1'b0;
    cyc(3);
    chk("rstmid_no_starts", 32'(start_n - starts0), 0);
    chk("rstmid_config", {31'd0, Wt_Ready}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
